// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default timing for the PLL lock supervisor.
// State encoding is visible on the state port, so it must stay fixed.
package pll_lock_supervisor_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1000000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
// One down-counter, reloaded on every state entry, times all states.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count,
  output logic       timeout_flag
);

  localparam int unsigned MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int          CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LOAD_RST    = CW'(RST_CYCLES);
  localparam logic [CW-1:0] LOAD_LOCK   = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] LOAD_SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TERMINAL    = CW'(1);

  sup_state_t    st;
  logic [CW-1:0] cnt;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  assign state = st;

  // The counter holds the cycles left in the current state; the last one is
  // spent when it reads 1, so a load of N keeps the state for exactly N cycles.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      st              <= PLL_RST;
      cnt             <= LOAD_RST;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      lock_loss_count <= 8'd0;
      timeout_flag    <= 1'b0;
    end else begin
      case (st)
        PLL_RST: begin
          if (cnt == TERMINAL) begin
            st      <= WAIT_LOCK;
            cnt     <= LOAD_LOCK;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (cnt == TERMINAL) begin
            st           <= PLL_RST;
            cnt          <= LOAD_RST;
            pll_rst      <= 1'b1;
            timeout_flag <= 1'b1;
          end else if (lock_s) begin
            st  <= SETTLE;
            cnt <= LOAD_SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          // A dropout wins over a coinciding terminal count.
          if (!lock_s) begin
            st  <= WAIT_LOCK;
            cnt <= LOAD_LOCK;
          end else if (cnt == TERMINAL) begin
            st      <= RUN;
            sys_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            st      <= PLL_RST;
            cnt     <= LOAD_RST;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
          end
        end
        default: begin
          st      <= PLL_RST;
          cnt     <= LOAD_RST;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock
// activity, scored against a cycle-level behavioural model.
module tb_pll_lock_supervisor;

  localparam int RST = 4;
  localparam int TO  = 50;
  localparam int SET = 8;
  localparam int W   = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic [1:0] state;
  logic [7:0] lock_loss_count;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .SETTLE_CYCLES (SET)
  ) dut (
    .refclk          (clk),
    .rst             (rst),
    .locked          (locked),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .state           (state),
    .lock_loss_count (lock_loss_count),
    .timeout_flag    (timeout_flag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input int st, input bit pr, input bit sr,
                                        input int cnt, input bit tf);
    logic [1:0] s2;
    logic [7:0] c8;
    s2 = st[1:0];
    c8 = cnt[7:0];
    return {s2, pr, sr, c8, tf};
  endfunction

  // ---------------- reference model ----------------
  // Phase numbers: 0 PLL reset, 1 wait lock, 2 settle, 3 run.
  int m_phase, m_elapsed, m_count;
  bit m_flag;
  bit samp[$];

  always @(posedge clk) begin
    bit used;
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_count = 0; m_flag = 0;
      samp = '{1'b0, 1'b0};
    end else begin
      used = samp.pop_front();   // locked as seen two edges ago
      samp.push_back(locked);
      case (m_phase)
        0: begin
          m_elapsed++;
          if (m_elapsed == RST) begin m_phase = 1; m_elapsed = 0; end
        end
        1: begin
          m_elapsed++;
          if (m_elapsed == TO) begin m_phase = 0; m_elapsed = 0; m_flag = 1; end
          else if (used) begin m_phase = 2; m_elapsed = 0; end
        end
        2: begin
          if (!used) begin m_phase = 1; m_elapsed = 0; end
          else begin
            m_elapsed++;
            if (m_elapsed == SET) begin m_phase = 3; m_elapsed = 0; end
          end
        end
        default: begin
          if (!used) begin
            m_phase = 0; m_elapsed = 0;
            if (m_count < 255) m_count++;
          end
        end
      endcase
    end
    exp_q.push_back(pack(m_phase, m_phase == 0, m_phase != 3, m_count, m_flag));
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {state, pll_rst, sys_rst, lock_loss_count, timeout_flag};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got st=%0d pll_rst=%b sys_rst=%b cnt=%0d tf=%b exp st=%0d pll_rst=%b sys_rst=%b cnt=%0d tf=%b",
                 $time, g[12:11], g[10], g[9], g[8:1], g[0], e[12:11], e[10], e[9], e[8:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at posedge+2; leaves time at posedge+2 after n edges.
  task automatic hold(input bit v, input int n);
    locked = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_rst", sys_rst, 1);
    chk("reset_count", lock_loss_count, 0);
    chk("reset_flag", timeout_flag, 0);
    rst = 1'b0;

    // clean lock
    hold(1'b0, 10);
    hold(1'b1, 40);
    chk("clean_state", state, 3);
    chk("clean_sys_rst", sys_rst, 0);
    chk("clean_count", lock_loss_count, 0);

    // lock loss in RUN: sys_rst within 3 edges
    hold(1'b0, 3);
    chk("loss_sys_rst", sys_rst, 1);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_count", lock_loss_count, 1);
    hold(1'b0, 5);

    // glitch in SETTLE
    hold(1'b1, 5);
    hold(1'b0, 1);
    hold(1'b1, 3);
    chk("glitch_sys_rst", sys_rst, 1);
    hold(1'b1, 27);
    chk("glitch_run", state, 3);

    // timeout
    hold(1'b0, 3);
    hold(1'b0, 150);
    chk("timeout_flag", timeout_flag, 1);
    chk("timeout_count", lock_loss_count, 2);

    // randomized lock activity
    repeat (150) hold(1'($urandom_range(0, 1)), $urandom_range(1, 70));

    // saturation
    hold(1'b1, 30);
    repeat (300) begin
      hold(1'b0, 4);
      hold(1'b1, 20);
    end
    chk("sat_count", lock_loss_count, 255);
    chk("sat_state", state, 3);

    // asynchronous reset between edges while in RUN
    #5;
    rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_rst", sys_rst, 1);
    chk("async_count", lock_loss_count, 0);
    chk("async_flag", timeout_flag, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    hold(1'b0, 60);
    hold(1'b1, 30);

    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
